// File: rtl/exp_engine_arbiter.sv
// exp_engine_arbiter: round-robin sharing of one e^x engine among N_REQ requesters.
// Build option: define EXP_ARB_TIMEOUT_EN to enable the WAIT-state watchdog.
module exp_engine_arbiter #(
    parameter int N_REQ          = 4,
    parameter int X_W            = 16,
    parameter int INT_W          = 2,
    parameter int FRAC_W         = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*X_W-1:0]   reqX,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       resValid,
    output logic [INT_W-1:0]       resInt,
    output logic [FRAC_W-1:0]      resFrac,
    output logic                   resErr,
    output logic                   busy,
    output logic                   engStart,
    output logic [X_W-1:0]         engX,
    input  logic                   engDone,
    input  logic [INT_W-1:0]       engInt,
    input  logic [FRAC_W-1:0]      engFrac,
    output logic                   dbg_state
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [PW-1:0]     r_ptr, r_owner, w_sel;
    logic              w_found, w_launch, w_finish, w_done_rise;
    logic              r_done_q, r_busy, r_eng_start;
    logic [N_REQ-1:0]  r_grant, r_res_valid;
    logic [INT_W-1:0]  r_res_int;
    logic [FRAC_W-1:0] r_res_frac;
    logic [X_W-1:0]    r_eng_x;
    logic [X_W-1:0]    w_x [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_split
        assign w_x[gi] = reqX[gi*X_W +: X_W];
    end

    // Search starts one past the last owner so every requester gets a turn.
    always_comb begin : arb
        int            j;
        logic [PW-1:0] w_idx;
        j       = 0;
        w_idx   = '0;
        w_found = 1'b0;
        w_sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            w_idx = PW'(j);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    // A rise seen in the engStart cycle belongs to the previous operation.
    assign w_done_rise = engDone & ~r_done_q & ~r_eng_start;

`ifdef EXP_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          w_tmo;

    always_ff @(posedge clk) begin
        if (rst || w_launch) r_tmo_cnt <= '0;
        else if (r_state == S_WAIT && r_tmo_cnt != TW'(TIMEOUT_CYCLES))
            r_tmo_cnt <= r_tmo_cnt + TW'(1);
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = 1'b0;
        w_finish    = 1'b0;
`ifdef EXP_ARB_TIMEOUT_EN
        w_tmo       = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_launch    = 1'b1;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_done_rise) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`ifdef EXP_ARB_TIMEOUT_EN
                else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
`endif
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= PW'(N_REQ - 1);
            r_owner     <= '0;
            r_done_q    <= 1'b0;
            r_busy      <= 1'b0;
            r_eng_start <= 1'b0;
            r_eng_x     <= '0;
            r_grant     <= '0;
            r_res_valid <= '0;
            r_res_int   <= '0;
            r_res_frac  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_done_q    <= engDone;
            r_grant     <= '0;
            r_eng_start <= 1'b0;
            r_res_valid <= '0;
            if (w_launch) begin
                r_grant     <= ONE_HOT0 << w_sel;
                r_eng_start <= 1'b1;
                r_eng_x     <= w_x[w_sel];
                r_owner     <= w_sel;
                r_ptr       <= w_sel;
                r_busy      <= 1'b1;
            end
            if (w_finish) begin
                r_res_valid <= ONE_HOT0 << r_owner;
                r_res_int   <= engInt;
                r_res_frac  <= engFrac;
                r_busy      <= 1'b0;
            end
`ifdef EXP_ARB_TIMEOUT_EN
            if (w_tmo) begin
                r_res_valid <= ONE_HOT0 << r_owner;
                r_res_int   <= '0;
                r_res_frac  <= '0;
                r_busy      <= 1'b0;
            end
`endif
        end
    end

`ifdef EXP_ARB_TIMEOUT_EN
    logic r_res_err;

    always_ff @(posedge clk) begin
        if (rst)           r_res_err <= 1'b0;
        else if (w_finish) r_res_err <= 1'b0;
        else if (w_tmo)    r_res_err <= 1'b1;
    end
    assign resErr = r_res_err;
`else
    // Without the watchdog the timeout limit has no effect on the logic.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_unused
    end
    assign resErr = 1'b0;
`endif

    assign grant     = r_grant;
    assign resValid  = r_res_valid;
    assign resInt    = r_res_int;
    assign resFrac   = r_res_frac;
    assign busy      = r_busy;
    assign engStart  = r_eng_start;
    assign engX      = r_eng_x;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_exp_engine_arbiter.sv
// Bench for exp_engine_arbiter: engine stub with real-valued e^x model, scoreboard queue,
// table-driven arbitration vectors and hand sequences for reset abort and engine hang.
module tb_exp_engine_arbiter;
  localparam int N  = 4;
  localparam int XW = 16;
  localparam int IW = 2;
  localparam int FW = 16;
  localparam int EW = 3 + 1 + IW + FW;
`ifdef EXP_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 4096;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*XW-1:0] reqX;
  logic [N-1:0]    grant, resValid;
  logic [IW-1:0]   resInt;
  logic [FW-1:0]   resFrac;
  logic            resErr, busy, engStart, dbg_state;
  logic [XW-1:0]   engX;
  logic            engDone;
  logic [IW-1:0]   engInt;
  logic [FW-1:0]   engFrac;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  logic            hang = 1'b0;
  logic            expect_tmo = 1'b0;
  int              lat_cnt = 0;
  logic [XW-1:0]   eng_x_lat;
  logic [XW-1:0]   x_hold;
  logic [N-1:0]    req_s;
  logic [N*XW-1:0] reqX_s;

  exp_engine_arbiter #(
    .N_REQ(N), .X_W(XW), .INT_W(IW), .FRAC_W(FW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .reqX(reqX), .grant(grant), .resValid(resValid),
    .resInt(resInt), .resFrac(resFrac), .resErr(resErr), .busy(busy), .engStart(engStart),
    .engX(engX), .engDone(engDone), .engInt(engInt), .engFrac(engFrac), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [IW+FW-1:0] exp_model(input logic [XW-1:0] x);
    real r;
    r = $exp(real'(x) / 65536.0) * 65536.0;
    return (IW+FW)'($rtoi(r));
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic check_tol(input string name, input logic [63:0] act, input logic [63:0] expv,
                           input int tol);
    longint d;
    n_checks++;
    d = longint'(act) - longint'(expv);
    if (d < 0) d = -d;
    if (d > tol) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h +-%0d", name, act, expv, tol);
    end
  endtask

  // ---------------- engine stub ----------------
  initial begin
    engDone = 1'b0;
    engInt  = '0;
    engFrac = '0;
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      engDone = 1'b0;
      lat_cnt = 0;
    end else if (engStart) begin
      eng_x_lat = engX;
      engDone   = 1'b0;
      lat_cnt   = $urandom_range(2, 6);
    end else if (lat_cnt > 0) begin
      lat_cnt--;
      if (lat_cnt == 0 && !hang) begin
        engDone           = 1'b1;
        {engInt, engFrac} = exp_model(eng_x_lat);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  always @(posedge clk) begin
    req_s  <= req;
    reqX_s <= reqX;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (grant != '0) begin
        int gi;
        gi = idx_of(grant);
        x_hold = reqX_s[gi*XW +: XW];
        check("grant_onehot", 64'($countones(grant)), 64'd1);
        check("grant_was_requested", 64'((grant & req_s) != '0), 64'd1);
        check("engstart_with_grant", 64'(engStart), 64'd1);
        check("engx_routed", 64'(engX), 64'(x_hold));
        check("busy_on_grant", 64'(busy), 64'd1);
        exp_q.push_back({3'(gi), expect_tmo, expect_tmo ? '0 : exp_model(x_hold)});
      end else if (busy) begin
        check("engx_stable", 64'(engX), 64'(x_hold));
        check("engstart_single", 64'(engStart), 64'd0);
      end
      if (resValid != '0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: resValid=0x%0h with nothing outstanding", resValid);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("res_owner", 64'(resValid), 64'(4'b0001 << e[EW-1 -: 3]));
          check("res_err", 64'(resErr), 64'(e[IW+FW]));
          check("res_value", 64'({resInt, resFrac}), 64'(e[IW+FW-1:0]));
          check("busy_clear", 64'(busy), 64'd0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_grant(output logic [N-1:0] g, output int cyc);
    g   = '0;
    cyc = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (grant != '0) begin
        g   = grant;
        cyc = c;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL grant_timeout: no grant within 64 cycles, required one");
  endtask

  task automatic wait_result(output logic [N-1:0] v, output int cyc);
    v   = '0;
    cyc = 0;
    for (int c = 1; c <= 64; c++) begin
      @(negedge clk);
      if (resValid != '0) begin
        v   = resValid;
        cyc = c;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL result_timeout: no resValid within 64 cycles, required one");
  endtask

  task automatic do_reset(input int cycles);
    req = '0;
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    exp_q.delete();
    rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  typedef struct {
    logic [N-1:0]     mask;
    int               idx;
    logic [IW+FW-1:0] val;
  } vec_t;
  vec_t tbl[12];

  logic [N-1:0] g, v;
  int           c;
  int           hold_seq[8] = '{1, 3, 1, 3, 1, 2, 3, 1};

  initial begin
    // operands: req0=0.5, req1=0.75, req2=0.25, req3=0.0
    tbl[0]  = '{4'b1111, 0, 18'h1A612};
    tbl[1]  = '{4'b1111, 1, 18'h21DF3};
    tbl[2]  = '{4'b1111, 2, 18'h148B5};
    tbl[3]  = '{4'b1111, 3, 18'h10000};
    tbl[4]  = '{4'b1111, 0, 18'h1A612};
    tbl[5]  = '{4'b0110, 1, 18'h21DF3};
    tbl[6]  = '{4'b1001, 3, 18'h10000};
    tbl[7]  = '{4'b0110, 1, 18'h21DF3};
    tbl[8]  = '{4'b0101, 2, 18'h148B5};
    tbl[9]  = '{4'b0001, 0, 18'h1A612};
    tbl[10] = '{4'b1000, 3, 18'h10000};
    tbl[11] = '{4'b1100, 2, 18'h148B5};

    rst  = 1'b1;
    req  = 4'b1111;
    reqX = {16'h0000, 16'h4000, 16'hC000, 16'h8000};

    // reset with all requests pending
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs",
            64'({grant, resValid, resInt, resFrac, resErr, busy, engStart}), 64'd0);
      check("reset_engx", 64'(engX), 64'd0);
    end
    exp_q.delete();
    rst = 1'b0;
    wait_grant(g, c);
    check("first_grant_after_reset", 64'(g), 64'b0001);
    check("first_grant_latency", 64'(c), 64'd1);
    req = '0;
    wait_result(v, c);
    check("first_result_owner", 64'(v), 64'b0001);

    // single request, done-edge to result timing
    @(negedge clk);
    req = 4'b0001;
    wait_grant(g, c);
    req = '0;
    check("single_grant", 64'(g), 64'b0001);
    check("single_grant_latency", 64'(c), 64'd1);
    for (int k = 0; k < 64 && !engDone; k++) begin
      @(negedge clk);
    end
    check("no_result_before_done_seen", 64'(resValid), 64'd0);
    @(negedge clk);
    check("done_to_result_latency", 64'(resValid), 64'b0001);
    check("half_int", 64'(resInt), 64'd1);
    check_tol("half_frac", 64'(resFrac), 64'hA612, 1);
    check("result_is_engine_value", 64'({resInt, resFrac}), 64'({engInt, engFrac}));

    // table-driven round-robin vectors from the reset pointer
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].mask;
      wait_grant(g, c);
      req = '0;
      check("tbl_grant", 64'(g), 64'(4'b0001 << tbl[i].idx));
      check("tbl_grant_latency", 64'(c), 64'd1);
      wait_result(v, c);
      check("tbl_owner", 64'(v), 64'(4'b0001 << tbl[i].idx));
      check_tol("tbl_value", 64'({resInt, resFrac}), 64'(tbl[i].val), 1);
    end

    // held requests alternate; req2 joins after a req1 grant
    @(negedge clk);
    do_reset(2);
    req = 4'b1010;
    for (int k = 0; k < 8; k++) begin
      wait_grant(g, c);
      check("hold_grant_order", 64'(g), 64'(4'b0001 << hold_seq[k]));
      if (k == 4) req[2] = 1'b1;
      wait_result(v, c);
      check("hold_result_order", 64'(v), 64'(4'b0001 << hold_seq[k]));
      if (k == 7) req = '0;
    end

    // reset mid-operation aborts the op, held request re-granted afterwards
    @(negedge clk);
    hang = 1'b1;
    req  = 4'b0100;
    wait_grant(g, c);
    check("abort_grant", 64'(g), 64'b0100);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_engstart", 64'(engStart), 64'd0);
    check("abort_no_result", 64'(resValid), 64'd0);
    exp_q.delete();
    hang = 1'b0;
    rst  = 1'b0;
    wait_grant(g, c);
    check("regrant_after_reset", 64'(g), 64'b0100);
    check("regrant_latency", 64'(c), 64'd1);
    req = '0;
    wait_result(v, c);
    check("regrant_result", 64'(v), 64'b0100);

    // random masks and operands
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) reqX[i*XW +: XW] = 16'($urandom_range(0, 65535));
      req = 4'($urandom_range(1, 15));
      wait_grant(g, c);
      req = '0;
      wait_result(v, c);
      check("rand_owner_matches_grant", 64'(v), 64'(g));
    end

    // engine never completes
    @(negedge clk);
    hang = 1'b1;
`ifdef EXP_ARB_TIMEOUT_EN
    expect_tmo = 1'b1;
    @(negedge clk);
    req = 4'b0010;
    wait_grant(g, c);
    req = '0;
    wait_result(v, c);
    check("timeout_owner", 64'(v), 64'b0010);
    check("timeout_latency", 64'(c), 64'd17);
    check("timeout_err", 64'(resErr), 64'd1);
    check("timeout_value", 64'({resInt, resFrac}), 64'd0);
    expect_tmo = 1'b0;
    hang = 1'b0;
`else
    req = 4'b0010;
    wait_grant(g, c);
    req = '0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (10000) begin
        @(negedge clk);
        if (resValid != '0) seen = 1'b1;
      end
      check("hang_no_result", 64'(seen), 64'd0);
      check("hang_busy_held", 64'(busy), 64'd1);
      check("hang_err_low", 64'(resErr), 64'd0);
    end
    hang = 1'b0;
    do_reset(2);
`endif

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
